// File: rtl/blur_pkg.sv
// Shared encodings for the horizontal blur line sequencer: FSM states, kernel radii and
// tag field layout.
package blur_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPrePad,
    StActive,
    StPostPad,
    StDrain
  } state_e;

  localparam int unsigned R5  = 2;
  localparam int unsigned R11 = 5;

  localparam int unsigned TagW     = 4;
  localparam int unsigned TagValid = 0;
  localparam int unsigned TagSol   = 1;
  localparam int unsigned TagEol   = 2;
  localparam int unsigned TagEof   = 3;

  typedef logic [TagW-1:0] tag_t;

  function automatic logic [2:0] tap_radius(input logic toggle);
    return toggle ? 3'(R11) : 3'(R5);
  endfunction

endpackage

// File: rtl/blur_line_sequencer_if.sv
// Pixel-in / convolver-out bundle of the blur line sequencer.
// The slave side is the sequencer, the master side is the source plus downstream observer.
interface blur_line_sequencer_if;

  logic [7:0] in_pixel;
  logic       in_valid;
  logic       in_sof;
  logic       in_ready;
  logic       mode_req;
  logic [7:0] conv_pixel;
  logic       conv_toggle;
  logic       out_valid;
  logic       out_sol;
  logic       out_eol;
  logic       out_eof;
  logic       underrun;
  logic       busy;

  modport master (
    output in_pixel, in_valid, in_sof, mode_req,
    input  in_ready, conv_pixel, conv_toggle, out_valid, out_sol, out_eol, out_eof,
    input  underrun, busy
  );

  modport slave (
    input  in_pixel, in_valid, in_sof, mode_req,
    output in_ready, conv_pixel, conv_toggle, out_valid, out_sol, out_eol, out_eof,
    output underrun, busy
  );

endinterface

// File: rtl/blur_tag_pipe.sv
// Column tag delay line: six stages deep, tapped after R5+1 or R11+1 cycles so each tag
// lines up with the centred convolver result.
module blur_tag_pipe
  import blur_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_sel_long,
  input  tag_t i_tag,
  output tag_t o_tag,
  output logic o_empty
);

  tag_t r_stage [R11+1];
  logic w_live;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k <= R11; k++) r_stage[k] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int unsigned k = 1; k <= R11; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  // Stages beyond the active tap are dead and never hold back a mode change.
  always_comb begin
    w_live = 1'b0;
    for (int unsigned k = 0; k <= R11; k++) begin
      if (k <= (i_sel_long ? R11 : R5)) w_live = w_live | r_stage[k][TagValid];
    end
  end

  assign o_tag   = i_sel_long ? r_stage[R11] : r_stage[R5];
  assign o_empty = ~w_live;

endmodule

// File: rtl/blur_line_sequencer.sv
// Feeds the horizontal Gaussian convolver one padded line at a time and tags real columns.
// Define BLUR_ZERO_PAD_EN for zero padding; otherwise edge pixels are replicated.
module blur_line_sequencer
  import blur_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned COL_W      = 10,
  parameter int unsigned ROW_W      = 9
) (
  input logic            clk,
  input logic            rst_n,
  blur_line_sequencer_if.slave bus
);

  localparam logic [COL_W-1:0] LastCol = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LastRow = ROW_W'(IMG_HEIGHT - 1);

  state_e           r_state;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [2:0]       r_cnt;
  logic [7:0]       r_edge;
  logic [7:0]       r_conv;
  logic             r_toggle;
  logic             r_underrun;

  logic [2:0] w_r;
  logic       w_ready;
  logic       w_xfer;
  logic       w_empty;
  logic [7:0] w_pad_in;
  logic [7:0] w_pad_edge;
  tag_t       w_tag;
  tag_t       w_tag_out;

`ifdef BLUR_ZERO_PAD_EN
  assign w_pad_in   = '0;
  assign w_pad_edge = '0;
`else
  assign w_pad_in   = bus.in_pixel;
  assign w_pad_edge = r_edge;
`endif

  assign w_r    = tap_radius(r_toggle);
  assign w_xfer = bus.in_valid & w_ready;

  // A frame start must wait for the old tags to leave, since it may change the pipe depth.
  always_comb begin
    w_ready = 1'b0;
    unique case (r_state)
      StIdle:   w_ready = bus.in_sof ? w_empty : (r_row != '0);
      StActive: w_ready = (r_col != LastCol);
      default:  w_ready = 1'b0;
    endcase
  end

  always_comb begin
    w_tag = '0;
    if (r_state == StActive) begin
      w_tag[TagValid] = 1'b1;
      w_tag[TagSol]   = (r_col == '0);
      w_tag[TagEol]   = (r_col == LastCol);
      w_tag[TagEof]   = (r_col == LastCol) && (r_row == LastRow);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_col      <= '0;
      r_row      <= '0;
      r_cnt      <= '0;
      r_edge     <= '0;
      r_conv     <= '0;
      r_toggle   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_conv <= '0;
          if (w_xfer) begin
            r_edge  <= bus.in_pixel;
            r_conv  <= w_pad_in;
            r_cnt   <= '0;
            r_col   <= '0;
            r_state <= StPrePad;
            if (bus.in_sof) begin
              r_toggle   <= bus.mode_req;
              r_row      <= '0;
              r_underrun <= 1'b0;
            end
          end
        end
        StPrePad: begin
          if (r_cnt == w_r - 3'd1) begin
            r_conv  <= r_edge;
            r_col   <= '0;
            r_state <= StActive;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        StActive: begin
          if (r_col == LastCol) begin
            r_conv  <= w_pad_edge;
            r_cnt   <= '0;
            r_col   <= '0;
            r_state <= StPostPad;
          end else begin
            r_col <= r_col + COL_W'(1);
            // A missing beat repeats the current column so the line length never changes.
            if (bus.in_valid) begin
              r_edge <= bus.in_pixel;
              r_conv <= bus.in_pixel;
            end else begin
              r_underrun <= 1'b1;
            end
          end
        end
        StPostPad: begin
          if (r_cnt == w_r - 3'd1) begin
            r_conv <= '0;
            r_cnt  <= '0;
            if (r_row == LastRow) begin
              r_row   <= '0;
              r_state <= StDrain;
            end else begin
              r_row   <= r_row + ROW_W'(1);
              r_state <= StIdle;
            end
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        StDrain: begin
          r_conv <= '0;
          if (r_cnt == w_r) r_state <= StIdle;
          else              r_cnt   <= r_cnt + 3'd1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  blur_tag_pipe u_tag_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sel_long (r_toggle),
    .i_tag      (w_tag),
    .o_tag      (w_tag_out),
    .o_empty    (w_empty)
  );

  assign bus.in_ready    = w_ready;
  assign bus.conv_pixel  = r_conv;
  assign bus.conv_toggle = r_toggle;
  assign bus.out_valid   = w_tag_out[TagValid];
  assign bus.out_sol     = w_tag_out[TagSol];
  assign bus.out_eol     = w_tag_out[TagEol];
  assign bus.out_eof     = w_tag_out[TagEof];
  assign bus.underrun    = r_underrun;
  assign bus.busy        = (r_state != StIdle) || !w_empty;

endmodule
